// File: rtl/limbus_sys_perf_cntr_mp.sv
// Multi-section cycle/event performance counter, Avalon-MM slave.
// Ports: clk, reset_n, address, begintransfer, read, write, writedata,
//        hw_go, hw_stop (per-section pulses), readdata (registered).
module limbus_sys_perf_cntr_mp #(
  parameter int NUM_SECTIONS = 4,
  parameter int TIME_W       = 64,
  parameter int EVT_W        = 32,
  parameter int ADDR_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    begintransfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic [NUM_SECTIONS-1:0] hw_go,
  input  logic [NUM_SECTIONS-1:0] hw_stop,
  output logic [31:0]             readdata
);

  localparam int SEC_W = ADDR_W - 2;

  logic [SEC_W-1:0]        w_sec;
  logic [1:0]              w_word;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_greset;
  logic                    w_gen;
  logic [NUM_SECTIONS-1:0] w_sel;
  logic [NUM_SECTIONS-1:0] w_stop;
  logic [NUM_SECTIONS-1:0] w_go;
  logic [NUM_SECTIONS-1:0] w_tinc;
  logic [NUM_SECTIONS-1:0] w_einc;
  logic [NUM_SECTIONS-1:0] w_tov_set;
  logic [NUM_SECTIONS-1:0] w_eov_set;
  logic [NUM_SECTIONS-1:0] w_tov_clr;
  logic [NUM_SECTIONS-1:0] w_eov_clr;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  logic [NUM_SECTIONS-1:0] r_en;
  logic [NUM_SECTIONS-1:0] r_tov;
  logic [NUM_SECTIONS-1:0] r_eov;
  logic [TIME_W-1:0]       r_time   [NUM_SECTIONS];
  logic [EVT_W-1:0]        r_evt    [NUM_SECTIONS];
  logic [31:0]             r_shadow [NUM_SECTIONS];
  logic [31:0]             r_rdata;

  assign w_sec    = address[ADDR_W-1:2];
  assign w_word   = address[1:0];
  assign w_wr     = write & begintransfer;
  assign w_rd     = read & begintransfer;
  assign w_unused = ^writedata[31:3];
  assign readdata = r_rdata;

  // Section indices at or above NUM_SECTIONS never match, so they are absent.
  always_comb begin
    w_sel     = '0;
    w_stop    = '0;
    w_go      = '0;
    w_tov_clr = '0;
    w_eov_clr = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      w_sel[s]  = (w_sec == SEC_W'(s));
      w_stop[s] = (w_wr & w_sel[s] & (w_word == 2'd0)) | hw_stop[s];
      w_go[s]   = (w_wr & w_sel[s] & (w_word == 2'd1)) | hw_go[s];
      w_tov_clr[s] = w_wr & w_sel[s] & (w_word == 2'd3) & writedata[1];
      w_eov_clr[s] = w_wr & w_sel[s] & (w_word == 2'd3) & writedata[2];
    end
  end

  assign w_greset = w_wr & w_sel[0] & (w_word == 2'd0) & writedata[0];
  assign w_gen    = r_en[0] | w_go[0];

  // Wrap is detected on the all-ones value about to increment.
  always_comb begin
    w_tinc    = '0;
    w_einc    = '0;
    w_tov_set = '0;
    w_eov_set = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      w_tinc[s]    = r_en[s] & w_gen;
      w_einc[s]    = w_go[s] & w_gen;
      w_tov_set[s] = w_tinc[s] & (&r_time[s]);
      w_eov_set[s] = w_einc[s] & (&r_evt[s]);
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (w_sel[s]) begin
        unique case (w_word)
          2'd0: w_rdata = r_time[s][31:0];
          2'd1: w_rdata = r_shadow[s];
          2'd2: w_rdata = 32'(r_evt[s]);
          2'd3: w_rdata = {29'b0, r_eov[s], r_tov[s], r_en[s]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en    <= '0;
      r_tov   <= '0;
      r_eov   <= '0;
      r_rdata <= '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        r_time[s]   <= '0;
        r_evt[s]    <= '0;
        r_shadow[s] <= '0;
      end
    end else begin
      r_rdata <= w_rdata;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        if (w_greset) begin
          r_en[s]   <= 1'b0;
          r_tov[s]  <= 1'b0;
          r_eov[s]  <= 1'b0;
          r_time[s] <= '0;
          r_evt[s]  <= '0;
        end else begin
          if (w_stop[s])
            r_en[s] <= 1'b0;
          else if (w_go[s])
            r_en[s] <= 1'b1;
          if (w_tinc[s])
            r_time[s] <= r_time[s] + TIME_W'(1);
          if (w_einc[s])
            r_evt[s] <= r_evt[s] + EVT_W'(1);
          // A coinciding wrap beats the W1C clear.
          r_tov[s] <= w_tov_set[s] | (r_tov[s] & ~w_tov_clr[s]);
          r_eov[s] <= w_eov_set[s] | (r_eov[s] & ~w_eov_clr[s]);
        end
        // High word is frozen with the low-word read for atomic 64-bit reads.
        if (w_rd & w_sel[s] & (w_word == 2'd0))
          r_shadow[s] <= 32'(r_time[s][TIME_W-1:32]);
      end
    end
  end

endmodule

// File: tb/tb_limbus_sys_perf_cntr_mp.sv
// Self-checking bench for limbus_sys_perf_cntr_mp.
// Reads are queued with expected data and checked when readdata returns.
module tb_limbus_sys_perf_cntr_mp;

  localparam int NS = 4;
  localparam int TW = 40;
  localparam int EW = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          begintransfer = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [NS-1:0] hw_go = '0;
  logic [NS-1:0] hw_stop = '0;
  logic [31:0]   readdata;

  typedef struct {
    int          s;
    int          w;
    logic [31:0] exp;
  } rd_t;

  rd_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  limbus_sys_perf_cntr_mp #(
    .NUM_SECTIONS(NS),
    .TIME_W(TW),
    .EVT_W(EW),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .begintransfer(begintransfer),
    .read(read),
    .write(write),
    .writedata(writedata),
    .hw_go(hw_go),
    .hw_stop(hw_stop),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic wr(input int s, input int w, input logic [31:0] d);
    @(negedge clk);
    address       = AW'(s * 4 + w);
    writedata     = d;
    write         = 1'b1;
    begintransfer = 1'b1;
    @(posedge clk);
    #1;
    write         = 1'b0;
    begintransfer = 1'b0;
    writedata     = '0;
  endtask

  task automatic bus_read(input int s, input int w, output logic [31:0] d);
    @(negedge clk);
    address       = AW'(s * 4 + w);
    read          = 1'b1;
    begintransfer = 1'b1;
    @(posedge clk);
    #1;
    d             = readdata;
    read          = 1'b0;
    begintransfer = 1'b0;
  endtask

  task automatic expect_rd(input int s, input int w, input logic [31:0] e);
    rd_t t;
    t.s   = s;
    t.w   = w;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic test_reset();
    rd_t t;
    logic [31:0] got;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected %h", readdata, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++)
        expect_rd(s, w, 32'h0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL reset s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  task automatic test_global_gate();
    rd_t t;
    logic [31:0] got;
    wr(1, 1, 0);
    repeat (9) @(posedge clk);
    wr(1, 0, 0);
    expect_rd(1, 0, 32'd0);
    expect_rd(1, 2, 32'd0);
    expect_rd(1, 3, 32'd0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL gate_off s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    wr(0, 1, 0);
    wr(1, 1, 0);
    repeat (9) @(posedge clk);
    wr(1, 0, 0);
    expect_rd(1, 0, 32'd10);
    expect_rd(1, 1, 32'd0);
    expect_rd(1, 2, 32'd1);
    expect_rd(1, 3, 32'd0);
    expect_rd(0, 3, 32'd1);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL gate_on s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  task automatic test_shadow();
    rd_t t;
    logic [31:0] got;
    @(negedge clk);
    dut.r_time[1] = 40'h00_FFFF_FFFE;
    expect_rd(1, 0, 32'hFFFF_FFFE);
    expect_rd(1, 1, 32'h0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL shadow_pre s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    wr(1, 1, 0);
    repeat (4) @(posedge clk);
    expect_rd(1, 1, 32'h0);
    expect_rd(1, 0, 32'h0000_0003);
    expect_rd(1, 1, 32'h1);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL shadow_carry s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    wr(1, 0, 0);
    expect_rd(1, 2, 32'd2);
    expect_rd(1, 3, 32'd0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL shadow_post s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  task automatic test_hw_pulse();
    rd_t t;
    logic [31:0] got;
    @(negedge clk);
    hw_go   = 4'b0100;
    hw_stop = 4'b0100;
    @(posedge clk);
    #1;
    hw_go   = '0;
    hw_stop = '0;
    repeat (3) @(posedge clk);
    expect_rd(2, 0, 32'd0);
    expect_rd(2, 2, 32'd1);
    expect_rd(2, 3, 32'd0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL hw_pulse s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  task automatic test_tov();
    rd_t t;
    logic [31:0] got;
    @(negedge clk);
    dut.r_time[2] = '1;
    wr(2, 1, 0);
    repeat (1) @(posedge clk);
    wr(2, 0, 0);
    expect_rd(2, 0, 32'd1);
    expect_rd(2, 2, 32'd2);
    expect_rd(2, 3, 32'h2);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL tov_set s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    wr(2, 3, 32'h2);
    wr(5, 1, 0);
    expect_rd(2, 3, 32'h0);
    expect_rd(2, 0, 32'd1);
    expect_rd(5, 3, 32'h0);
    expect_rd(5, 2, 32'h0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL tov_clr s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  task automatic test_evt_wrap();
    rd_t t;
    logic [31:0] got;
    for (int i = 0; i < 4; i++)
      wr(3, 1, 0);
    expect_rd(3, 2, 32'd0);
    expect_rd(3, 3, 32'h5);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL evt_wrap s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    wr(3, 3, 32'h4);
    wr(3, 2, 32'h7);
    expect_rd(3, 3, 32'h1);
    expect_rd(3, 2, 32'd0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL eov_clr s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    wr(0, 0, 32'h1);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 4; w++)
        expect_rd(s, w, 32'h0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL greset s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    rd_t t;
    logic [31:0] got;
    wr(0, 1, 0);
    wr(1, 1, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    address = AW'(1);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_rdata: got %h expected %h", readdata, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 4; w++)
        expect_rd(s, w, 32'h0);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL async s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
    @(negedge clk);
    hw_go = 4'b0001;
    @(posedge clk);
    #1;
    hw_go = '0;
    repeat (3) @(posedge clk);
    expect_rd(0, 0, 32'd3);
    expect_rd(0, 2, 32'd1);
    expect_rd(0, 3, 32'd1);
    while (sb.size() > 0) begin
      t = sb.pop_front();
      bus_read(t.s, t.w, got);
      n_tests++;
      if (got !== t.exp) begin
        n_fail++;
        $display("FAIL resume s%0d w%0d: got %h expected %h",
                 t.s, t.w, got, t.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_global_gate();
    test_shadow();
    test_hw_pulse();
    test_tov();
    test_evt_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
